// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter_tick block set.
//   state_t          : controller states (IDLE, RUN, EXPIRED)
//   DEFAULT_PRESCALE : clk cycles per tick for board builds
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam int DEFAULT_PRESCALE = 67108864;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: emits a one-cycle registered tick every PRESCALE
// enabled cycles. Intended for reuse by any counter in the block set.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous, active-low reset
//   clear  in  zero the count and suppress tick (takes priority over enable)
//   enable in  advance the count; when low the count is frozen
//   tick   out one-cycle pulse, registered
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/down_counter_tick.sv
// Loadable down counter stepped by a prescaled clock-enable tick. Counts from
// the loaded value to 0, pulses done on reaching 0, then parks in EXPIRED.
// Optional build macro DOWN_COUNTER_AUTO_RELOAD_EN: a tick at q==0 reloads the
// last loaded value and the counter keeps running instead of expiring.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous, active-low reset
//   start    in  load load_val and begin counting (any state)
//   pause    in  freeze count and prescaler while in RUN
//   load_val in  start value, captured on start
//   q        out current count, registered
//   tick     out one-cycle prescaler pulse, registered
//   busy     out high in RUN
//   done     out one-cycle pulse in the first cycle q shows 0
//   expired  out high in EXPIRED
module down_counter_tick
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_val, reload_nxt;
`endif

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable ((state == RUN) && !pause),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            done  <= done_nxt;
        end
    end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (!rst) reload_val <= '0;
        else      reload_val <= reload_nxt;
    end
`endif

    // A tick issued just before pause rises is still consumed; pause only
    // stops new ticks from being generated.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        done_nxt  = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_nxt = reload_val;
        if (start) begin
            q_nxt      = load_val;
            reload_nxt = load_val;
            state_nxt  = RUN;
        end else if ((state == RUN) && tick) begin
            if (q > WIDTH'(1)) begin
                q_nxt = q - 1'b1;
            end else if (q == WIDTH'(1)) begin
                q_nxt    = '0;
                done_nxt = 1'b1;
            end else begin
                // With a zero reload value every tick lands on 0 again.
                q_nxt    = reload_val;
                done_nxt = (reload_val == '0);
            end
        end
`else
        if (start) begin
            q_nxt = load_val;
            if (load_val == '0) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else if ((state == RUN) && tick) begin
            if (q > WIDTH'(1)) begin
                q_nxt = q - 1'b1;
            end else if (q == WIDTH'(1)) begin
                q_nxt     = '0;
                done_nxt  = 1'b1;
                state_nxt = EXPIRED;
            end
        end
`endif
    end

    assign busy    = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: doc/down_counter_tick.md
Name: down_counter_tick

Overview:
- Loadable down counter; the counting-direction counterpart of the board up counter.
- Decrements once per prescaled tick from a loaded start value, flags terminal count, then stops.
- All logic runs on the single clk domain; the slow rate is a clock-enable tick, never a derived clock.
- Drives LED/seven-segment countdown displays and timeout indications on the board.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 67108864, clk cycles per tick; legal range is 2 or more. Benches override with a small value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  load load_val and begin counting; sampled every cycle
- pause  in  1  freeze count and prescaler while high in RUN
- load_val  in  WIDTH  start value, captured on start
- q  out  WIDTH  current count, registered
- tick  out  1  one-cycle prescaler pulse, registered
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in the first cycle q shows terminal value
- expired  out  1  level, high in EXPIRED

Behaviour:
- Reset (rst low at an edge), including mid-run:
  - state=IDLE; q=0; tick=0; done=0; busy=0; expired=0; prescaler count=0.
- States:
  - IDLE: waits for start.
  - RUN: counts down.
  - EXPIRED: q=0, waits for start.
- start, accepted in any state and highest priority after reset:
  - q<=load_val; reload_val<=load_val; prescaler count<=0.
  - load_val!=0: next state RUN.
  - load_val==0: next state EXPIRED, with done=1 in the following cycle.
  - start while already in RUN restarts cleanly and emits no done.
- Prescaler:
  - Counts only in RUN with pause low.
  - When its count equals PRESCALE-1, the count wraps to 0 and tick is asserted for exactly one cycle.
  - Timing: the first tick is high PRESCALE cycles after start is sampled; q decrements at the edge where tick is high.
  - Result: q=load_val-1 becomes visible PRESCALE+1 cycles after the start edge, and subsequent decrements occur every PRESCALE cycles.
- Decrement rule, at an edge in RUN with tick high:
  - q>1: q<=q-1.
  - q==1: q<=0, state<=EXPIRED, done=1 next cycle, expired=1 next cycle.
- pause high in RUN:
  - Prescaler count and q are held, no tick is issued, busy stays 1.
  - Counting resumes from the frozen prescaler value.
  - pause is ignored in IDLE and EXPIRED.
- busy=1 exactly when state==RUN. expired=1 exactly when state==EXPIRED.
- No wrap below 0 in the base build; q never underflows.
- Arithmetic is unsigned, modulo-free.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - In RUN, a tick with q==0 reloads q<=reload_val and the block stays in RUN; EXPIRED is never entered from RUN.
  - A tick with q==1 still sets q<=0 and pulses done.
  - Period is reload_val+1 ticks.
  - If reload_val==0, start enters RUN, q stays 0, and done pulses after every tick.
- Undefined: base behaviour above; the reload path is not synthesized.

Decomposition:
- Package down_counter_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2.
  - Default PRESCALE constant.
- Sub-module tick_prescaler:
  - Ports: clk, rst, clear, enable, tick.
  - Internal counter width is $clog2(PRESCALE).
  - Reused by any future up counter in the block set.

Test Plan:
- Reset mid-run: WIDTH=4, PRESCALE=4. Start with load_val=3, then hold rst low for 1 cycle while q=2 -> next cycle state IDLE, q=0, busy=0, done=0, tick=0.
- Basic countdown: PRESCALE=4, start with load_val=3 -> q=3, then 2 after 5 cycles, 1 after 9, 0 after 13. done high exactly in cycle 13 only; expired=1 from cycle 13; busy low from cycle 13.
- Zero load: start with load_val=0 -> next cycle q=0, expired=1, done pulse for 1 cycle, busy never high.
- Pause: load_val=5, pause for 10 cycles starting 2 cycles after start -> q stays 5 during pause, no tick; first decrement arrives 10 cycles later than unpaused.
- Restart while running: start with load_val=9 while q=4 -> q=9 next cycle, no done, prescaler restarts so the next decrement is PRESCALE cycles later.
- Auto-reload (macro defined): load_val=2, PRESCALE=4 -> q sequence 2,1,0,2,1,0; done on each entry to 0; busy stays 1; expired stays 0.
